// File: rtl/ascii_7to1_serializer.sv
// ASCII 7-to-1 serializer: FIFO-buffered characters out as a gapless MSB-first bitstream.
// Optional SER_PARITY_EN appends an even-parity bit, making frames 8 cycles long.
module ascii_7to1_serializer #(
  parameter int         DEPTH     = 4,
  parameter logic [6:0] FILL_CHAR = 7'h00,
  parameter int         LVL_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             frame_start,
  output logic             fill_active,
  output logic [LVL_W-1:0] level,
  output logic [7:0]       fill_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
`ifdef SER_PARITY_EN
  localparam logic [2:0] LAST_BIT = 3'd7;
`else
  localparam logic [2:0] LAST_BIT = 3'd6;
`endif
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE  = (PTR_W+1)'(1);

  logic [6:0]     r_mem [DEPTH];
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  logic [2:0]     r_bit_cnt;
  logic [5:0]     r_shift;
  logic           r_ser_out;
  logic           r_frame_start;
  logic           r_fill_active;
  logic [7:0]     r_fill_cnt;
`ifdef SER_PARITY_EN
  logic           r_parity;
`endif

  logic [PTR_W:0] w_count;
  logic           w_empty;
  logic           w_full;
  logic           w_boundary;
  logic           w_push;
  logic           w_pop;
  logic [6:0]     w_head;
  logic [6:0]     w_word;
  logic [2:0]     w_bit_cnt_next;
  logic [5:0]     w_shift_next;
  logic           w_ser_next;
  logic           w_fill_active_next;
  logic [7:0]     w_fill_cnt_next;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (w_count == '0);
  assign w_full     = (w_count == FULL_CNT);
  assign w_boundary = (r_bit_cnt == 3'd0);
  assign w_push     = in_valid && !w_full;
  assign w_pop      = w_boundary && !w_empty;
  assign w_head     = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_word     = w_empty ? FILL_CHAR : w_head;

  assign in_ready    = !w_full;
  assign level       = LVL_W'(w_count);
  assign ser_out     = r_ser_out;
  assign frame_start = r_frame_start;
  assign fill_active = r_fill_active;
  assign fill_cnt    = r_fill_cnt;

  always_comb begin
    w_bit_cnt_next     = r_bit_cnt;
    w_shift_next       = r_shift;
    w_ser_next         = r_ser_out;
    w_fill_active_next = r_fill_active;
    w_fill_cnt_next    = r_fill_cnt;
    if (w_boundary) begin
      w_ser_next         = w_word[6];
      w_shift_next       = w_word[5:0];
      w_fill_active_next = w_empty;
      w_bit_cnt_next     = 3'd1;
      if (w_empty && (r_fill_cnt != 8'hFF)) begin
        w_fill_cnt_next = r_fill_cnt + 8'd1;
      end
    end else begin
      w_ser_next     = r_shift[5];
      w_shift_next   = {r_shift[4:0], 1'b0};
      w_bit_cnt_next = (r_bit_cnt == LAST_BIT) ? 3'd0 : r_bit_cnt + 3'd1;
`ifdef SER_PARITY_EN
      if (r_bit_cnt == 3'd7) begin
        w_ser_next = r_parity;
      end
`endif
    end
  end

  // Storage is not reset: clearing the pointers is enough to discard contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 6'd0;
      r_ser_out     <= 1'b0;
      r_frame_start <= 1'b0;
      r_fill_active <= 1'b0;
      r_fill_cnt    <= 8'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_bit_cnt     <= w_bit_cnt_next;
      r_shift       <= w_shift_next;
      r_ser_out     <= w_ser_next;
      r_frame_start <= w_boundary;
      r_fill_active <= w_fill_active_next;
      r_fill_cnt    <= w_fill_cnt_next;
    end
  end

`ifdef SER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_boundary) begin
      r_parity <= ^w_word;
    end
  end
`endif

endmodule

// File: doc/ascii_7to1_serializer.md
Name: ascii_7to1_serializer

Overview:
- Upstream feeder for the 1-to-7 ASCII deserializer stage: accepts 7-bit ASCII characters over a valid/ready handshake and emits them as a continuous MSB-first serial bitstream, one bit per clk.
- Characters are buffered in a small FIFO.
- The downstream stage has no framing input and samples continuously, so the output never stalls: when the FIFO is empty at a character boundary, a fill character is sent instead.

Parameters:
- DEPTH, 4: FIFO depth in characters; power of 2, minimum 2.
- FILL_CHAR, 7'h00: character sent when no data is queued (NUL).
- LVL_W, 3: width of the level output; must hold DEPTH (log2(DEPTH)+1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  7  ASCII character to queue.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a character; equals !full.
- ser_out  output  1  serial bit, registered, MSB of each character first.
- frame_start  output  1  high in the cycle where ser_out carries bit 6 of a character.
- fill_active  output  1  high for all 7 bits of a frame that carries FILL_CHAR.
- level  output  LVL_W  current FIFO occupancy.
- fill_cnt  output  8  saturating count of fill frames sent since reset.

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: FIFO empty, level=0, in_ready=1, bit_cnt=0, ser_out=0, frame_start=0, fill_active=0, fill_cnt=0, shift register=0.
- Reset asserted mid-frame aborts the frame and discards FIFO contents. After release, the first rising edge starts a new frame.
- Push: occurs when in_valid && in_ready at a rising edge. in_data is written at the write pointer; the pointer wraps modulo DEPTH.
- in_valid while in_ready=0: ignored and not stored. The source must hold the data.
- bit_cnt runs 0..6 and wraps to 0. Frame length is exactly 7 cycles, with no gaps between frames.
- Boundary cycle (bit_cnt==0):
  - Select word = FIFO head if level>0, else FILL_CHAR.
  - If the head is taken, pop it (read pointer advances, wraps modulo DEPTH).
  - ser_out<=word[6]; shift register<=word[5:0]; frame_start<=1; fill_active<=(level==0); bit_cnt<=1.
  - If fill is taken, fill_cnt increments and saturates at 255.
- Cycles with bit_cnt 1..6: ser_out<=next MSB of the shift register, then shift left; frame_start<=0; fill_active holds; bit_cnt advances (6 wraps to 0).
- Latency: a character pushed at edge t is sent at the first boundary edge strictly after t.
  - No same-cycle bypass: a push into an empty FIFO on a boundary edge yields a fill frame now, and the character goes in the next frame.
  - Minimum latency is 1 cycle; worst case with an empty FIFO is 7 cycles until bit 6 appears.
- Push and pop on the same boundary edge: both take effect; level unchanged.
- Full FIFO: in_ready=0, so no push. A pop on a boundary makes in_ready=1 from the next cycle (level is registered).
- level and in_ready are derived from registered pointers only, with no combinational path from in_valid.
- Character order is strictly FIFO; no character is lost or duplicated.

Optional Feature:
- Macro: SER_PARITY_EN.
- When defined:
  - Each frame becomes 8 cycles: 7 data bits MSB first, then an even-parity bit (XOR of the 7 data bits).
  - bit_cnt runs 0..7. Fill frames carry parity of FILL_CHAR.
  - frame_start and fill_active keep the same meaning.
- When undefined: 7-cycle frames, no parity logic synthesized.

Test Plan:
- Reset then idle 21 cycles, no in_valid: ser_out=0 throughout; frame_start high on cycles 1, 8, 15; fill_active=1; fill_cnt=3.
- Push 'H' (1001000) then 'i' (1101001) back-to-back into an empty FIFO just after a boundary: next frames emit 1001000, 1101001 MSB first with no gap; level returns to 0; fill_active=0 for both frames.
- Push 5 characters 'A'..'E' while DEPTH=4 and ser_out is mid-frame: in_ready drops after 4 pushes and 'E' is held. After the next boundary pop, in_ready rises, 'E' is accepted, and output order is A,B,C,D,E.
- Push 'Z' on the exact boundary edge with the FIFO empty: that frame is FILL_CHAR with fill_active=1; 'Z' (1011010) is sent in the following frame.
- Assert rst_n=0 mid-frame with 3 characters queued: outputs return to reset values immediately (asynchronously); after release, only fill frames are sent and level=0.
- With SER_PARITY_EN defined, push 'C' (1000011): emits 1000011 then parity bit 1; frame_start period is 8 cycles.
